cxu_dispatcher: RTL and testbench
=================================

Name: cxu_dispatcher

Overview:
- Sits between the CPU's single CXU command/response port and NUM_CXU downstream CXUs (e.g. the Q10 fixed-point multiply unit).
- Accepts one command at a time and routes it by cmd_payload_cxu_id. The downstream CXU may be combinational or multi-cycle.
- Returns the selected CXU's result to the CPU.
- Generates an error response for an out-of-range id, or when a CXU stalls past a timeout.

Parameters:
- NUM_CXU, 2, number of downstream CXUs (1..16).
- TIMEOUT_CYCLES, 256, max cycles spent in ISSUE+WAIT before the error response is forced.
- ERR_VALUE, 32'hFFFF_FFFF, result returned on bad id or timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CPU command valid
- cmd_ready  out  1  dispatcher can accept a command
- cmd_payload_function_id  in  3  function select
- cmd_payload_inputs_0  in  32  operand A
- cmd_payload_inputs_1  in  32  operand B
- cmd_payload_state_id  in  3  state context
- cmd_payload_cxu_id  in  4  target CXU index
- cmd_payload_ready  in  1  ignored
- rsp_valid  out  1  CPU response valid
- rsp_ready  in  1  CPU accepts response
- rsp_payload_outputs_0  out  32  result
- rsp_payload_ready  out  1  always equal to rsp_valid
- cxu_cmd_valid  out  NUM_CXU  one-hot command valid per CXU
- cxu_cmd_ready  in  NUM_CXU  per-CXU command ready
- cxu_function_id  out  3  latched, broadcast to all CXUs
- cxu_inputs_0  out  32  latched, broadcast
- cxu_inputs_1  out  32  latched, broadcast
- cxu_state_id  out  3  latched, broadcast
- cxu_rsp_valid  in  NUM_CXU  per-CXU response valid
- cxu_rsp_ready  out  NUM_CXU  one-hot response ready
- cxu_rsp_outputs  in  32*NUM_CXU  per-CXU results; CXU i occupies bits [32i+31:32i]
- err_pulse  out  1  one-cycle pulse on bad id or timeout
- err_code  out  2  0 none, 1 bad id, 2 timeout; held until the next accepted command

Behaviour:
- Reset values:
  - state=IDLE, all valid/ready outputs 0.
  - Latched payload, rsp_payload_outputs_0 and timeout counter all 0.
  - err_code=0, err_pulse=0.
  - A reset mid-transaction abandons the downstream transaction immediately, with no response.
- All outputs are registered or decoded from state; there is no combinational path from any input to any output.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch payload, latch id, clear err_code.
  - id>=NUM_CXU -> ERR, err_code=1. Otherwise -> ISSUE.
- ISSUE:
  - cxu_cmd_valid[id]=1 and cxu_rsp_ready[id]=1 together. This is required because combinational CXUs tie cmd_ready to rsp_ready.
  - On cxu_cmd_ready[id], if cxu_rsp_valid[id] is also high: capture cxu_rsp_outputs slice id -> RESP.
  - On cxu_cmd_ready[id] alone -> WAIT.
- WAIT:
  - cxu_cmd_valid=0, cxu_rsp_ready[id]=1.
  - On cxu_rsp_valid[id]: capture result -> RESP.
- Timeout:
  - Counter increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion -> ERR with err_code=2. Downstream valid/ready drop in the next cycle.
  - The counter clears on entry to ISSUE.
- ERR:
  - rsp_payload_outputs_0=ERR_VALUE; err_pulse=1 for the entry cycle only.
  - Behaves as RESP thereafter.
- RESP:
  - rsp_valid=1, output held stable until rsp_ready -> IDLE.
  - cmd_ready=0, so no command overlap (one outstanding transaction).
- Latency with a combinational CXU and rsp_ready held high:
  - command accepted in cycle T, ISSUE in T+1, rsp_valid in T+2.
  - Throughput is 1 command per 3 cycles.
- Responses from non-selected CXUs are ignored; their rsp_ready stays 0.
- rsp_ready arriving while not in RESP/ERR has no effect.

Decomposition:
- Package cxu_dispatch_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP, ERR}.
  - err_code constants ERR_NONE/ERR_BAD_ID/ERR_TIMEOUT.
  - CXU_ID_W=4, DATA_W=32.
- One sub-module, cxu_onehot_sel: index -> one-hot enable, plus the 32-bit output mux slice.
- The FSM, timeout counter and payload registers stay in the top module.

Test Plan:
- NUM_CXU=2, combinational Q10 multiplier on CXU0. Command id=0, inputs 0x00000800 and 0x00000C00 (2.0 x 3.0), rsp_ready=1 -> rsp_valid at T+2 with 0x00001800; cmd_ready low in T+1..T+2.
- Command id=5 -> ERR: rsp_payload_outputs_0=0xFFFFFFFF, err_pulse for one cycle, err_code=1; cxu_cmd_valid never asserted.
- CXU1 model returns 0x12345678 after 4 cycles -> state sequence ISSUE, WAIT x4, RESP; cxu_rsp_ready[1]=1 only; CXU0 handshakes stay 0.
- CXU1 never responds, TIMEOUT_CYCLES=8 -> ERR entered after 8 cycles in ISSUE/WAIT; err_code=2, rsp=0xFFFFFFFF.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable; a second cmd_valid is not accepted until one cycle after rsp_ready.
- Reset asserted during WAIT -> next cycle all outputs at reset values, state IDLE; a new command then completes normally.

Source files
------------

// File: rtl/cxu_dispatch_pkg.sv
// cxu_dispatch_pkg: shared widths, FSM state encodings and error codes for the CXU dispatcher.
package cxu_dispatch_pkg;
    localparam int CXU_ID_W = 4;
    localparam int DATA_W   = 32;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t ISSUE = 3'd1;
    localparam state_t WAIT  = 3'd2;
    localparam state_t RESP  = 3'd3;
    localparam state_t ERR   = 3'd4;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_ID  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/cxu_onehot_sel.sv
// cxu_onehot_sel: index to one-hot enable plus the matching W-bit slice of a packed bus.
module cxu_onehot_sel
    import cxu_dispatch_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic [CXU_ID_W-1:0] idx,
    input  logic [N*W-1:0]      data,
    output logic [N-1:0]        onehot,
    output logic [W-1:0]        sel
);
    always_comb begin
        onehot = '0;
        sel    = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == CXU_ID_W'(i)) begin
                onehot[i] = 1'b1;
                sel       = data[i*W +: W];
            end
        end
    end
endmodule

// File: rtl/cxu_dispatcher.sv
// cxu_dispatcher: routes one CPU CXU command at a time to one of NUM_CXU units and returns
// its result, or an error value on a bad id or a stalled unit.
module cxu_dispatcher
    import cxu_dispatch_pkg::*;
#(
    parameter int          NUM_CXU        = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_VALUE      = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_payload_function_id,
    input  logic [DATA_W-1:0]         cmd_payload_inputs_0,
    input  logic [DATA_W-1:0]         cmd_payload_inputs_1,
    input  logic [2:0]                cmd_payload_state_id,
    input  logic [CXU_ID_W-1:0]       cmd_payload_cxu_id,
    input  logic                      cmd_payload_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_payload_outputs_0,
    output logic                      rsp_payload_ready,
    output logic [NUM_CXU-1:0]        cxu_cmd_valid,
    input  logic [NUM_CXU-1:0]        cxu_cmd_ready,
    output logic [2:0]                cxu_function_id,
    output logic [DATA_W-1:0]         cxu_inputs_0,
    output logic [DATA_W-1:0]         cxu_inputs_1,
    output logic [2:0]                cxu_state_id,
    input  logic [NUM_CXU-1:0]        cxu_rsp_valid,
    output logic [NUM_CXU-1:0]        cxu_rsp_ready,
    input  logic [DATA_W*NUM_CXU-1:0] cxu_rsp_outputs,
    output logic                      err_pulse,
    output logic [1:0]                err_code
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state;
    logic [CXU_ID_W-1:0] id;
    logic [CW-1:0]       cnt;
    logic [NUM_CXU-1:0]  onehot;
    logic [DATA_W-1:0]   sel;
    logic                busy, hit_cmd, hit_rsp, done, timeout;
    logic                unused_ok;

    assign unused_ok = cmd_payload_ready;

    cxu_onehot_sel #(.N(NUM_CXU), .W(DATA_W)) u_sel (
        .idx    (id),
        .data   (cxu_rsp_outputs),
        .onehot (onehot),
        .sel    (sel)
    );

    // Handshakes are decoded only from the latched id, so no input reaches an output combinationally.
    assign busy    = (state == ISSUE) || (state == WAIT);
    assign hit_cmd = |(cxu_cmd_ready & onehot);
    assign hit_rsp = |(cxu_rsp_valid & onehot);
    assign done    = ((state == ISSUE) && hit_cmd && hit_rsp) || ((state == WAIT) && hit_rsp);
    assign timeout = busy && !done && (cnt == CW'(TIMEOUT_CYCLES - 1));

    assign cmd_ready         = state == IDLE;
    assign rsp_valid         = (state == RESP) || (state == ERR);
    assign rsp_payload_ready = rsp_valid;
    assign cxu_cmd_valid     = (state == ISSUE) ? onehot : '0;
    assign cxu_rsp_ready     = busy ? onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            id                    <= '0;
            cnt                   <= '0;
            cxu_function_id       <= '0;
            cxu_inputs_0          <= '0;
            cxu_inputs_1          <= '0;
            cxu_state_id          <= '0;
            rsp_payload_outputs_0 <= '0;
            err_pulse             <= 1'b0;
            err_code              <= ERR_NONE;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    id              <= cmd_payload_cxu_id;
                    cxu_function_id <= cmd_payload_function_id;
                    cxu_inputs_0    <= cmd_payload_inputs_0;
                    cxu_inputs_1    <= cmd_payload_inputs_1;
                    cxu_state_id    <= cmd_payload_state_id;
                    cnt             <= '0;
                    err_code        <= ERR_NONE;
                    if (int'(cmd_payload_cxu_id) >= NUM_CXU) begin
                        state                 <= ERR;
                        err_code              <= ERR_BAD_ID;
                        err_pulse             <= 1'b1;
                        rsp_payload_outputs_0 <= ERR_VALUE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE, WAIT: if (done) begin
                    state                 <= RESP;
                    rsp_payload_outputs_0 <= sel;
                end else if (timeout) begin
                    state                 <= ERR;
                    err_code              <= ERR_TIMEOUT;
                    err_pulse             <= 1'b1;
                    rsp_payload_outputs_0 <= ERR_VALUE;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (state == ISSUE && hit_cmd) state <= WAIT;
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cxu_dispatcher.sv
// tb_cxu_dispatcher: directed checks of the dispatcher against a combinational Q10 multiplier
// on CXU0 and a programmable-latency unit on CXU1.
module tb_cxu_dispatcher;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic [2:0]  cmd_payload_state_id = '0;
    logic [3:0]  cmd_payload_cxu_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_payload_outputs_0;
    logic        rsp_payload_ready;
    logic [1:0]  cxu_cmd_valid;
    logic [1:0]  cxu_cmd_ready;
    logic [2:0]  cxu_function_id;
    logic [31:0] cxu_inputs_0;
    logic [31:0] cxu_inputs_1;
    logic [2:0]  cxu_state_id;
    logic [1:0]  cxu_rsp_valid;
    logic [1:0]  cxu_rsp_ready;
    logic [63:0] cxu_rsp_outputs;
    logic        err_pulse;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;
    int lat = 0;
    int c1 = 0;
    logic signed [63:0] prod;

    cxu_dispatcher #(.NUM_CXU(2), .TIMEOUT_CYCLES(8), .ERR_VALUE(32'hFFFF_FFFF)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .cmd_payload_state_id(cmd_payload_state_id),
        .cmd_payload_cxu_id(cmd_payload_cxu_id),
        .cmd_payload_ready(1'b0),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .rsp_payload_ready(rsp_payload_ready),
        .cxu_cmd_valid(cxu_cmd_valid), .cxu_cmd_ready(cxu_cmd_ready),
        .cxu_function_id(cxu_function_id),
        .cxu_inputs_0(cxu_inputs_0), .cxu_inputs_1(cxu_inputs_1),
        .cxu_state_id(cxu_state_id),
        .cxu_rsp_valid(cxu_rsp_valid), .cxu_rsp_ready(cxu_rsp_ready),
        .cxu_rsp_outputs(cxu_rsp_outputs),
        .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // CXU0: combinational Q10 multiply, ready tied to rsp_ready.
    assign prod = 64'($signed(cxu_inputs_0)) * 64'($signed(cxu_inputs_1));
    assign cxu_cmd_ready[0] = cxu_rsp_ready[0];
    assign cxu_rsp_valid[0] = cxu_cmd_valid[0];
    // CXU1: accepts at once, answers lat cycles later (lat=0 never answers).
    assign cxu_cmd_ready[1] = 1'b1;
    assign cxu_rsp_valid[1] = c1 == 1;
    assign cxu_rsp_outputs  = {32'h1234_5678, 32'(prod >>> 10)};

    always @(posedge clk) begin
        if (reset) c1 <= 0;
        else if (cxu_cmd_valid[1] && cxu_cmd_ready[1]) c1 <= lat;
        else if (c1 > 1) c1 <= c1 - 1;
        else if (c1 == 1 && cxu_rsp_ready[1]) c1 <= 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b);
        cmd_valid            = 1'b1;
        cmd_payload_cxu_id   = id;
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_cxu_cmd_valid"}, 32'(cxu_cmd_valid), 0);
        chk({tag, "_cxu_rsp_ready"}, 32'(cxu_rsp_ready), 0);
        chk({tag, "_rsp_data"}, rsp_payload_outputs_0, 0);
        chk({tag, "_inputs_0"}, cxu_inputs_0, 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    endtask

    initial begin
        tick;
        tick;
        chk_reset_values("rst");
        reset = 1'b0;
        tick;
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        // Combinational multiply: 2.0 * 3.0 in Q10
        rsp_ready = 1'b1;
        send(4'd0, 32'h0000_0800, 32'h0000_0C00);
        tick;
        cmd_valid = 1'b0;
        chk("mul_t1_cmd_ready", 32'(cmd_ready), 0);
        chk("mul_t1_cxu_cmd_valid", 32'(cxu_cmd_valid), 32'b01);
        chk("mul_t1_cxu_rsp_ready", 32'(cxu_rsp_ready), 32'b01);
        chk("mul_t1_rsp_valid", 32'(rsp_valid), 0);
        tick;
        chk("mul_t2_rsp_valid", 32'(rsp_valid), 1);
        chk("mul_t2_payload_ready", 32'(rsp_payload_ready), 1);
        chk("mul_t2_data", rsp_payload_outputs_0, 32'h0000_1800);
        chk("mul_t2_cmd_ready", 32'(cmd_ready), 0);
        tick;
        chk("mul_back_idle", 32'(cmd_ready), 1);
        chk("mul_back_rsp_valid", 32'(rsp_valid), 0);
        // Bad id
        rsp_ready = 1'b0;
        send(4'd5, 32'h1, 32'h2);
        tick;
        cmd_valid = 1'b0;
        chk("badid_rsp_valid", 32'(rsp_valid), 1);
        chk("badid_data", rsp_payload_outputs_0, 32'hFFFF_FFFF);
        chk("badid_err_pulse", 32'(err_pulse), 1);
        chk("badid_err_code", 32'(err_code), 1);
        chk("badid_cxu_cmd_valid", 32'(cxu_cmd_valid), 0);
        tick;
        chk("badid_pulse_drop", 32'(err_pulse), 0);
        chk("badid_hold_valid", 32'(rsp_valid), 1);
        chk("badid_hold_code", 32'(err_code), 1);
        chk("badid_cxu_cmd_valid2", 32'(cxu_cmd_valid), 0);
        rsp_ready = 1'b1;
        tick;
        chk("badid_idle", 32'(cmd_ready), 1);
        chk("badid_code_kept", 32'(err_code), 1);
        // CXU1, 4-cycle latency
        lat = 4;
        send(4'd1, 32'hA, 32'hB);
        tick;
        cmd_valid = 1'b0;
        chk("slow_issue_cmd_valid", 32'(cxu_cmd_valid), 32'b10);
        chk("slow_issue_rsp_ready", 32'(cxu_rsp_ready), 32'b10);
        chk("slow_code_cleared", 32'(err_code), 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("slow_wait_cmd_valid", 32'(cxu_cmd_valid), 0);
            chk("slow_wait_rsp_ready", 32'(cxu_rsp_ready), 32'b10);
            chk("slow_wait_rsp_valid", 32'(rsp_valid), 0);
        end
        tick;
        chk("slow_resp_valid", 32'(rsp_valid), 1);
        chk("slow_resp_data", rsp_payload_outputs_0, 32'h1234_5678);
        chk("slow_resp_cxu_rsp_ready", 32'(cxu_rsp_ready), 0);
        tick;
        chk("slow_idle", 32'(cmd_ready), 1);
        // CXU1 never answers: timeout after 8 cycles in ISSUE/WAIT
        lat = 0;
        send(4'd1, 32'h3, 32'h4);
        tick;
        cmd_valid = 1'b0;
        chk("to_issue", 32'(cxu_cmd_valid), 32'b10);
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("to_wait_rsp_valid", 32'(rsp_valid), 0);
            chk("to_wait_rsp_ready", 32'(cxu_rsp_ready), 32'b10);
        end
        tick;
        chk("to_err_valid", 32'(rsp_valid), 1);
        chk("to_err_pulse", 32'(err_pulse), 1);
        chk("to_err_code", 32'(err_code), 2);
        chk("to_err_data", rsp_payload_outputs_0, 32'hFFFF_FFFF);
        chk("to_err_rsp_ready", 32'(cxu_rsp_ready), 0);
        tick;
        chk("to_idle", 32'(cmd_ready), 1);
        // Back-pressure: rsp_ready low for 5 cycles in RESP
        rsp_ready = 1'b0;
        send(4'd0, 32'h0000_0400, 32'h0000_1400);
        tick;
        send(4'd0, 32'h0000_0800, 32'h0000_0800);
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", rsp_payload_outputs_0, 32'h0000_1400);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            if (i < 4) tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_idle_ready", 32'(cmd_ready), 1);
        chk("bp_idle_cxu_cmd_valid", 32'(cxu_cmd_valid), 0);
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 0);
        tick;
        cmd_valid = 1'b0;
        chk("bp_second_issue", 32'(cxu_cmd_valid), 32'b01);
        chk("bp_second_inputs", cxu_inputs_0, 32'h0000_0800);
        tick;
        chk("bp_second_data", rsp_payload_outputs_0, 32'h0000_1000);
        tick;
        // Reset during WAIT
        lat = 4;
        send(4'd1, 32'h5, 32'h6);
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("rw_wait_rsp_ready", 32'(cxu_rsp_ready), 32'b10);
        reset = 1'b1;
        tick;
        chk_reset_values("rw");
        chk("rw_idle", 32'(cmd_ready), 1);
        reset = 1'b0;
        tick;
        send(4'd0, 32'h0000_0C00, 32'h0000_0C00);
        tick;
        cmd_valid = 1'b0;
        chk("rw_new_issue", 32'(cxu_cmd_valid), 32'b01);
        tick;
        chk("rw_new_valid", 32'(rsp_valid), 1);
        chk("rw_new_data", rsp_payload_outputs_0, 32'h0000_2400);
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
